div_iter: RTL and testbench

- Iterative radix-2 restoring divider.
- It is the responder side of the execute stage's divide interface: it receives operands, the op select and `div_enable` from execute, and returns `div_ready` and `div_result`.
- Execute holds `div_enable` high and stalls until `div_ready` pulses. Execute drops `div_enable` on clear or downstream stall, which aborts the operation.
- Implements RISC-V M-extension DIV/DIVU/REM/REMU semantics.

---
 rtl/div_iter.sv | 192 +++++++++++++++++++
 tb/tb_div_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Optional macro DIV_FAST_PATH_EN: zero divisor, signed overflow and |divisor| > |dividend| finish without iterating.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            div_enable,
    input  logic [XLEN-1:0] div_rdata1,
    input  logic [XLEN-1:0] div_rdata2,
    input  logic            div_op_div,
    input  logic            div_op_divu,
    input  logic            div_op_rem,
    input  logic            div_op_remu,
    output logic            div_ready,
    output logic [XLEN-1:0] div_result
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? negate(v) : v;
    endfunction

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            sel_rem_q, sel_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dzero_q, dzero_d;
    logic            ready_q;
    logic [XLEN-1:0] result_q, result_d;

    logic            req_signed_s, req_rem_s, dzero_s;
    logic [XLEN-1:0] dvd_mag_s, dvs_mag_s;
    logic [XLEN:0]   rem_shift_s, rem_diff_s;
    logic            take_s;
    logic [XLEN-1:0] rem_next_s, quo_next_s, quo_fix_s, rem_fix_s;
    logic            fast_s;
    logic [XLEN-1:0] fast_res_s;

    // Request decode; unsigned quotient is also the fallback when no op bit is set
    always_comb begin
        req_rem_s    = !div_op_divu && (div_op_rem || div_op_remu);
        req_signed_s = !div_op_divu && !div_op_remu && (div_op_div || div_op_rem);
        dvd_mag_s    = magnitude(div_rdata1, req_signed_s);
        dvs_mag_s    = magnitude(div_rdata2, req_signed_s);
        dzero_s      = (div_rdata2 == {XLEN{1'b0}});
    end

    // One restoring step on the XLEN+1 bit partial remainder, plus sign fix-up of its outcome
    always_comb begin
        rem_shift_s = {rem_q, quo_q[XLEN-1]};
        rem_diff_s  = rem_shift_s - {1'b0, dvs_q};
        take_s      = (rem_shift_s >= {1'b0, dvs_q});
        rem_next_s  = take_s ? rem_diff_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
        quo_next_s  = {quo_q[XLEN-2:0], take_s};
        quo_fix_s   = (neg_quo_q && !dzero_q) ? negate(quo_next_s) : quo_next_s;
        rem_fix_s   = neg_rem_q ? negate(rem_next_s) : rem_next_s;
    end

`ifdef DIV_FAST_PATH_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic ovf_s;
    logic [XLEN-1:0] fast_quo_s, fast_rem_s;

    // Requests whose result is known without iterating
    always_comb begin
        ovf_s = req_signed_s && (div_rdata1 == MIN_NEG) && (div_rdata2 == {XLEN{1'b1}});
        fast_s = dzero_s || ovf_s || (dvs_mag_s > dvd_mag_s);
        if (dzero_s) begin
            fast_quo_s = {XLEN{1'b1}};
            fast_rem_s = div_rdata1;
        end else if (ovf_s) begin
            fast_quo_s = MIN_NEG;
            fast_rem_s = {XLEN{1'b0}};
        end else begin
            fast_quo_s = {XLEN{1'b0}};
            fast_rem_s = div_rdata1;
        end
        fast_res_s = req_rem_s ? fast_rem_s : fast_quo_s;
    end
`else
    // Every request iterates
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = {XLEN{1'b0}};
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        sel_rem_d = sel_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dzero_d   = dzero_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (div_enable) begin
                    sel_rem_d = req_rem_s;
                    neg_quo_d = req_signed_s && (div_rdata1[XLEN-1] ^ div_rdata2[XLEN-1]);
                    neg_rem_d = req_signed_s && div_rdata1[XLEN-1];
                    dzero_d   = dzero_s;
                    cnt_d     = CNT_LAST;
                    rem_d     = {XLEN{1'b0}};
                    quo_d     = dvd_mag_s;
                    dvs_d     = dvs_mag_s;
                    if (fast_s) begin
                        state_d  = S_DONE;
                        result_d = fast_res_s;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!div_enable) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = quo_next_s;
                    rem_d = rem_next_s;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d  = S_DONE;
                        result_d = sel_rem_q ? rem_fix_s : quo_fix_s;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            quo_q     <= {XLEN{1'b0}};
            rem_q     <= {XLEN{1'b0}};
            dvs_q     <= {XLEN{1'b0}};
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dzero_q   <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            sel_rem_q <= sel_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dzero_q   <= dzero_d;
            ready_q   <= (state_d == S_DONE);
            result_q  <= result_d;
        end
    end

    assign div_ready  = ready_q;
    assign div_result = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed table, random ops against an arithmetic model, abort/reset/back-to-back sequences.
module tb_div_iter;
    localparam int XLEN    = 32;
    localparam int OP_DIV  = 0;
    localparam int OP_DIVU = 1;
    localparam int OP_REM  = 2;
    localparam int OP_REMU = 3;
    localparam int OP_NONE = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        div_enable;
    logic [31:0] div_rdata1, div_rdata2;
    logic        div_op_div, div_op_divu, div_op_rem, div_op_remu;
    logic        div_ready;
    logic [31:0] div_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    div_iter #(.XLEN(XLEN)) dut (
        .clock      (clock),
        .reset      (reset),
        .div_enable (div_enable),
        .div_rdata1 (div_rdata1),
        .div_rdata2 (div_rdata2),
        .div_op_div (div_op_div),
        .div_op_divu(div_op_divu),
        .div_op_rem (div_op_rem),
        .div_op_remu(div_op_remu),
        .div_ready  (div_ready),
        .div_result (div_result)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          op;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input int op,
                           input logic [31:0] exp, input string name);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_op(input int op);
        div_op_div  = (op == OP_DIV);
        div_op_divu = (op == OP_DIVU);
        div_op_rem  = (op == OP_REM);
        div_op_remu = (op == OP_REMU);
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input int op);
        longint sa, sb;
        bit is_rem;
        is_rem = (op == OP_REM) || (op == OP_REMU);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_DIV:  return 32'(sa / sb);
            OP_REM:  return 32'(sa % sb);
            OP_REMU: return a % b;
            default: return a / b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b, input int op);
`ifdef DIV_FAST_PATH_EN
        bit sgn;
        longint ma, mb;
        sgn = (op == OP_DIV) || (op == OP_REM);
        ma = sgn ? longint'($signed(a)) : longint'(a);
        mb = sgn ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || mb > ma) return 2;
`endif
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issues one request from a negedge, scrambles inputs after the start edge, checks latency, result, single pulse.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int op, input string name);
        logic [31:0] exp;
        int lat, cyc;
        bit seen;
        exp = ref_result(a, b, op);
        lat = ref_latency(a, b, op);
        div_rdata1 = a; div_rdata2 = b; set_op(op); div_enable = 1'b1;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clock); @(negedge clock);
            cyc++;
            div_rdata1 = 32'($urandom); div_rdata2 = 32'($urandom); set_op(int'($urandom_range(0, 3)));
            seen = div_ready;
        end
        check({name, " ready seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " result"}, div_result, exp);
        div_enable = 1'b0;
        @(posedge clock); @(negedge clock);
        check({name, " single pulse"}, 32'(div_ready), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, last, lat;
        reset = 1'b1; div_enable = 1'b0; div_rdata1 = '0; div_rdata2 = '0; set_op(OP_NONE);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset ready", 32'(div_ready), 32'd0);
        check("reset result", div_result, 32'd0);
        reset = 1'b0;
        @(posedge clock); @(negedge clock);

        add_vec(32'd100,        32'd7,          OP_DIVU, 32'd14,         "divu 100/7");
        add_vec(32'd100,        32'd7,          OP_REMU, 32'd2,          "remu 100/7");
        add_vec(32'hFFFF_FF9C,  32'd7,          OP_DIV,  32'hFFFF_FFF2,  "div -100/7");
        add_vec(32'hFFFF_FF9C,  32'd7,          OP_REM,  32'hFFFF_FFFE,  "rem -100/7");
        add_vec(32'd5,          32'd0,          OP_DIV,  32'hFFFF_FFFF,  "div 5/0");
        add_vec(32'hFFFF_FFFB,  32'd0,          OP_REM,  32'hFFFF_FFFB,  "rem -5/0");
        add_vec(32'hFFFF_FFFB,  32'd0,          OP_DIV,  32'hFFFF_FFFF,  "div -5/0");
        add_vec(32'd5,          32'd0,          OP_REMU, 32'd5,          "remu 5/0");
        add_vec(32'h8000_0000,  32'hFFFF_FFFF,  OP_DIV,  32'h8000_0000,  "div ovf");
        add_vec(32'h8000_0000,  32'hFFFF_FFFF,  OP_REM,  32'd0,          "rem ovf");
        add_vec(32'h8000_0000,  32'hFFFF_FFFF,  OP_DIVU, 32'd0,          "divu big");
        add_vec(32'd7,          32'hFFFF_FFFE,  OP_DIV,  32'hFFFF_FFFD,  "div 7/-2");
        add_vec(32'd7,          32'hFFFF_FFFE,  OP_REM,  32'd1,          "rem 7/-2");
        add_vec(32'hFFFF_FFF9,  32'd2,          OP_REM,  32'hFFFF_FFFF,  "rem -7/2");
        add_vec(32'd7,          32'd9,          OP_REMU, 32'd7,          "remu 7/9");
        add_vec(32'hFFFF_FFFF,  32'd1,          OP_DIVU, 32'hFFFF_FFFF,  "divu max/1");
        add_vec(32'd100,        32'd7,          OP_NONE, 32'd14,         "no op 100/7");

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].name);

        for (int i = 0; i < 40; i++) begin
            do_op(rnd_operand(), rnd_operand(), int'($urandom_range(0, 4)), $sformatf("random %0d", i));
        end

        // Enable held high through two operations: one pulse each, second starts right after DONE
        lat = ref_latency(32'd100, 32'd7, OP_DIVU);
        div_rdata1 = 32'd100; div_rdata2 = 32'd7; set_op(OP_DIVU); div_enable = 1'b1;
        pulses = 0; last = 0;
        for (int c = 2; c <= 2 * lat; c++) begin
            @(posedge clock); @(negedge clock);
            if (div_ready) begin
                pulses++; last = c;
                check("held result", div_result, 32'd14);
            end
        end
        div_enable = 1'b0;
        check("held pulse count", 32'(pulses), 32'd2);
        check("held second pulse cycle", 32'(last), 32'(2 * lat));
        @(posedge clock); @(negedge clock);
        check("held no extra pulse", 32'(div_ready), 32'd0);

        // Abort in BUSY cycle 10, re-request two cycles later
        div_rdata1 = 32'd1000; div_rdata2 = 32'd3; set_op(OP_DIVU); div_enable = 1'b1;
        pulses = 0;
        @(posedge clock); @(negedge clock);
        for (int i = 1; i < 10; i++) begin
            @(posedge clock); @(negedge clock);
            pulses += int'(div_ready);
        end
        div_enable = 1'b0;
        repeat (2) begin
            @(posedge clock); @(negedge clock);
            pulses += int'(div_ready);
        end
        check("abort no ready", 32'(pulses), 32'd0);
        check("abort result held", div_result, 32'd14);
        do_op(32'd9, 32'd2, OP_DIVU, "after abort");

        // Reset at iteration 20
        div_rdata1 = 32'd1000; div_rdata2 = 32'd3; set_op(OP_DIVU); div_enable = 1'b1;
        @(posedge clock); @(negedge clock);
        repeat (19) begin @(posedge clock); @(negedge clock); end
        reset = 1'b1; div_enable = 1'b0;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        check("mid reset ready", 32'(div_ready), 32'd0);
        check("mid reset result", div_result, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clock); @(negedge clock);
            pulses += int'(div_ready);
        end
        check("mid reset no ready", 32'(pulses), 32'd0);
        do_op(32'd1000, 32'd3, OP_DIVU, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
